// File: rtl/ssc_net.sv
// ssc_net: integer square root by successive subtraction of odd numbers,
// with every state flop on a single scan chain ending at the exact flop.
module ssc_net (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        busy,
    input  logic [15:0] data_in,
    output logic [15:0] rem_out,
    output logic [7:0]  root,
    output logic        exact,
    input  logic        Si,
    output logic        So,
    input  logic        NbarT
);
    typedef enum logic [3:0] {
        S_IDLE = 4'b1000,
        S_LOAD = 4'b0100,
        S_RUN  = 4'b0010,
        S_DONE = 4'b0001
    } state_t;

    state_t      r_state;
    logic        r_start_q;
    logic [16:0] r_rem;
    logic [8:0]  r_odd;
    logic [7:0]  r_root;
    logic [15:0] r_rem_out;
    logic        r_exact;

    state_t      w_state;
    logic [16:0] w_rem;
    logic [8:0]  w_odd;
    logic [7:0]  w_root;
    logic [15:0] w_rem_out;
    logic        w_exact;
    logic [55:0] w_chain;
    logic [55:0] w_d;

    always_comb begin
        w_state   = S_IDLE;
        w_rem     = r_rem;
        w_odd     = r_odd;
        w_root    = r_root;
        w_rem_out = r_rem_out;
        w_exact   = r_exact;
        case (r_state)
            S_IDLE: w_state = (start && !r_start_q) ? S_LOAD : S_IDLE;
            S_LOAD: begin
                w_rem   = {1'b0, data_in};
                w_odd   = 9'd1;
                w_root  = 8'd0;
                w_state = S_RUN;
            end
            S_RUN: begin
                if (r_rem >= {8'd0, r_odd}) begin
                    w_rem   = r_rem - {8'd0, r_odd};
                    w_odd   = r_odd + 9'd2;
                    w_root  = r_root + 8'd1;
                    w_state = S_RUN;
                end else begin
                    w_rem_out = r_rem[15:0];
                    w_exact   = (r_rem == 17'd0);
                    w_state   = S_DONE;
                end
            end
            S_DONE: w_state = S_IDLE;
            // zero or multiple one-hot bits recover to IDLE
            default: w_state = S_IDLE;
        endcase
    end

    assign w_chain = {r_state, r_start_q, r_rem, r_odd, r_root, r_rem_out, r_exact};
    assign w_d = NbarT ? {Si, w_chain[55:1]}
                       : {w_state, start, w_rem, w_odd, w_root, w_rem_out, w_exact};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_rem     <= '0;
            r_odd     <= '0;
            r_root    <= '0;
            r_rem_out <= '0;
            r_exact   <= 1'b0;
        end else begin
            r_state   <= state_t'(w_d[55:52]);
            r_start_q <= w_d[51];
            r_rem     <= w_d[50:34];
            r_odd     <= w_d[33:25];
            r_root    <= w_d[24:17];
            r_rem_out <= w_d[16:1];
            r_exact   <= w_d[0];
        end
    end

    assign done    = r_state[0];
    assign busy    = r_state[2] | r_state[1];
    assign root    = r_root;
    assign rem_out = r_rem_out;
    assign exact   = r_exact;
    assign So      = r_exact;
endmodule

// File: tb/tb_ssc_net.sv
// tb_ssc_net: random and directed square-root operations plus scan shifting,
// checked against an arithmetic reference model.
module tb_ssc_net;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic        busy;
    logic [15:0] data_in = '0;
    logic [15:0] rem_out;
    logic [7:0]  root;
    logic        exact;
    logic        Si = 1'b0;
    logic        So;
    logic        NbarT = 1'b0;

    int checks = 0;
    int failures = 0;

    ssc_net dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .data_in(data_in), .rem_out(rem_out), .root(root), .exact(exact),
        .Si(Si), .So(So), .NbarT(NbarT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic run_op(input logic [15:0] x, input string tag);
        int r;
        int n;
        r = isqrt(int'(x));
        data_in = x;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        check({tag, "_busy"}, busy, 1);
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, r + 3);
        check({tag, "_root"}, root, r);
        check({tag, "_rem"}, rem_out, int'(x) - r * r);
        check({tag, "_exact"}, exact, (int'(x) == r * r));
        tick();
        check({tag, "_done1"}, done, 0);
        check({tag, "_hold"}, rem_out, int'(x) - r * r);
    endtask

    task automatic scan(input logic [55:0] in_v, output logic [55:0] out_v);
        NbarT = 1'b1;
        for (int i = 0; i < 56; i++) begin
            Si = in_v[i];
            out_v[i] = So;
            tick();
        end
    endtask

    initial begin
        logic [55:0] alt;
        logic [55:0] rnd;
        logic [55:0] got;
        logic [55:0] rst_img;
        logic [15:0] x;
        int r;
        int n;
        int dones;
        rst_img = {4'b1000, 52'd0};
        for (int i = 0; i < 56; i++) alt[i] = (i % 2 == 0);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_root", root, 0);
        check("rst_rem", rem_out, 0);
        check("rst_exact", exact, 0);
        check("rst_so", So, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_op(16'd16, "x16");
        run_op(16'd20, "x20");
        run_op(16'd0, "x0");
        run_op(16'd65535, "xmax");
        for (int k = 0; k < 10; k++) begin
            x = 16'($urandom_range(0, 65535));
            run_op(x, $sformatf("rnd%0d", k));
        end
        // reset in the middle of a computation
        data_in = 16'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_root", root, 0);
        check("mid_rem", rem_out, 0);
        check("mid_exact", exact, 0);
        tick();
        rst = 1'b0;
        dones = 0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            dones += int'(done);
            n += int'(busy);
        end
        check("mid_nodone", dones, 0);
        check("mid_idle", n, 0);
        run_op(16'd1000, "x1000");
        // start held high triggers exactly once
        x = 16'd300;
        r = isqrt(300);
        data_in = x;
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < r + 40; i++) begin
            tick();
            dones += int'(done);
        end
        check("held_once", dones, 1);
        check("held_idle", busy, 0);
        start = 1'b0;
        tick();
        run_op(x, "held2");
        // scan chain: reset image, then alternating pattern round trip
        rst = 1'b1;
        tick();
        rst = 1'b0;
        scan(alt, got);
        check("scan_rstimg", got, rst_img);
        rnd = {$urandom, $urandom};
        scan(rnd, got);
        check("scan_alt", got, alt);
        scan(alt, got);
        check("scan_rnd", got, rnd);
        // reset wins over scan mode
        #2 rst = 1'b1;
        #1;
        check("scan_rst_so", So, 0);
        tick();
        rst = 1'b0;
        scan(alt, got);
        check("scan_rst_img", got, rst_img);
        // scanned-in RUN state continues normally
        x = 16'($urandom_range(0, 4000));
        r = isqrt(int'(x));
        scan({4'b0010, 1'b0, 1'b0, x, 9'd1, 8'd0, 16'd0, 1'b0}, got);
        NbarT = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("scanrun_lat", n, r + 1);
        check("scanrun_root", root, r);
        check("scanrun_rem", rem_out, int'(x) - r * r);
        check("scanrun_exact", exact, (int'(x) == r * r));
        tick();
        // illegal one-hot recovers to IDLE
        scan({4'b1111, 52'd0}, got);
        check("ill_done", done, 1);
        check("ill_busy", busy, 1);
        NbarT = 1'b0;
        tick();
        check("ill_done_clr", done, 0);
        check("ill_busy_clr", busy, 0);
        tick();
        run_op(16'd49, "x49");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ssc_net.md
SSC_NET -- requirements
Module: ssc_net

Interface
REQ-001 SHALL declare no parameters; widths are fixed.
REQ-002 clk  input  1  single clock, all flops rising-edge; one clock, reset is asynchronous and active-high.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  operation request, rising-edge detected.
REQ-005 done  output  1  high for exactly one cycle when a result is final.
REQ-006 busy  output  1  high while an operation is in progress.
REQ-007 data_in  input  16  unsigned operand X.
REQ-008 rem_out  output  16  final remainder, X minus root squared.
REQ-009 root  output  8  integer square root, floor(sqrt(X)).
REQ-010 exact  output  1  high when the last result had remainder 0.
REQ-011 Si  input  1  scan-chain serial input.
REQ-012 So  output  1  scan-chain serial output.
REQ-013 NbarT  input  1  1 = scan shift mode, 0 = normal operation.
REQ-014 Port order SHALL be: clk, rst, start, done, busy, data_in, rem_out, root, exact, Si, So, NbarT.

Function
REQ-015 Algorithm: successive subtraction of consecutive odd numbers (1, 3, 5, ...); the count of successful subtractions is the root.
REQ-016 State register: exactly 56 flops.
  - One-hot state: IDLE, LOAD, RUN, DONE (4).
  - start_q (1).
  - rem, 17 bits, bit 16 is guard.
  - odd (9).
  - root (8).
  - rem_out (16).
  - exact (1).
REQ-017 IDLE: when start is 1 and start_q is 0, go to LOAD; otherwise stay in IDLE. start_q <= start on every normal-mode edge.
REQ-018 LOAD: rem <= {0, data_in}, odd <= 1, root <= 0, then go to RUN. data_in SHALL be held stable through this edge.
REQ-019 RUN, each edge:
  - If rem >= odd: rem <= rem - odd, odd <= odd + 2, root <= root + 1, stay in RUN.
  - Otherwise: rem_out <= rem[15:0], exact <= (rem == 0), go to DONE.
REQ-020 DONE lasts one cycle, then returns to IDLE unconditionally.
REQ-021 done = DONE state bit; busy = LOAD or RUN state bit; both decoded combinationally from state flops.
REQ-022 Latency from the start-detect edge to done high: 2 + floor(sqrt(X)) + 1 cycles.
REQ-023 Arithmetic bounds:
  - root <= 255 and odd <= 511, so neither overflows.
  - X = 65535 gives root 255 and remainder 510.
REQ-024 rem_out and exact SHALL hold their values until the next RUN exit. root is valid from DONE until the next LOAD.
REQ-025 start is ignored outside IDLE. A start held high does not retrigger until it has returned to 0.
REQ-026 Scan mode (NbarT = 1):
  - All 56 flops form one shift register; normal function is suspended.
  - Chain order from Si: IDLE, LOAD, RUN, DONE, start_q, rem[16:0], odd[8:0], root[7:0], rem_out[15:0], exact.
  - So = the exact flop.
REQ-027 Scan shift takes one bit per clock. Shifting 56 bits SHALL fully replace the state, and the prior state appears on So in chain order, last flop first.
REQ-028 When NbarT returns to 0, the next edge SHALL perform a normal-mode update from the scanned-in state, including illegal one-hot states.
REQ-029 Illegal one-hot states (zero or several bits set) SHALL go to IDLE on the next normal edge.

Reset
REQ-030 rst = 1 SHALL immediately clear all flops except IDLE, which is set to 1. Outputs then read: done=0, busy=0, root=0, rem_out=0, exact=0, So=0.
REQ-031 Reset asserted mid-operation SHALL abort the computation. After release, the block stays in IDLE until a new start rising edge.
REQ-032 Reset SHALL override scan mode.

Verification
REQ-033 X=16, start pulse: busy high, then done high on cycle 7 after detect; root=4, rem_out=0, exact=1.
REQ-034 X=20: root=4, rem_out=4, exact=0. X=0: root=0, rem_out=0, exact=1, done 3 cycles after detect.
REQ-035 X=65535: root=255, rem_out=510, exact=0, done 258 cycles after detect.
REQ-036 rst pulse mid-RUN (X=1000): outputs clear immediately, no done is produced, and the next start with X=1000 yields root=31, rem_out=39.
REQ-037 Scan test: shift in 56 bits of alternating 1/0 with NbarT=1, then shift out 56 more; So reproduces the pattern, delayed by 56 clocks.
REQ-038 Start held high: exactly one operation completes, and a second completes only after start toggles 0 then 1.
